// File: rtl/pwm_mod_sweeper_if.sv
// Configuration port of the PWM modulation sweeper.
// A valid/ready offer of one complete sweep configuration.
interface pwm_mod_sweeper_if #(
    parameter int M    = 12,
    parameter int DIVW = 8
);
    logic            cfg_valid;
    logic            cfg_ready;
    logic [M-1:0]    cfg_min;
    logic [M-1:0]    cfg_max;
    logic [M-1:0]    cfg_step;
    logic [DIVW-1:0] cfg_div;
    logic            cfg_loop;

    // Configuration source (e.g. a register block or a testbench).
    modport master (
        output cfg_valid, cfg_min, cfg_max, cfg_step, cfg_div, cfg_loop,
        input  cfg_ready
    );

    // The sweeper itself.
    modport slave (
        input  cfg_valid, cfg_min, cfg_max, cfg_step, cfg_div, cfg_loop,
        output cfg_ready
    );
endinterface

// File: rtl/pwm_mod_sweeper.sv
// Duty-cycle sweeper for the PWM stage.
// Walks `modulation` between a min and a max in fixed steps, once every
// (div+1) phase-accumulator wraps. Duty only changes on a wrap, so each PWM
// period sees one constant duty value. New configurations are held in a
// shadow copy and take effect at the next wrap (or at once while idle).
// The interface instance must be built with the same M and DIVW as here.
module pwm_mod_sweeper #(
    parameter int N    = 14,
    parameter int M    = 12,
    parameter int DIVW = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N-1:0]            phase,
    input  logic                    run,
    pwm_mod_sweeper_if.slave        cfg,
    output logic [M-1:0]            modulation,
    output logic                    dir_down,
    output logic                    busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2,
        HOLD = 2'd3
    } state_t;

    typedef struct packed {
        logic [M-1:0]    min;
        logic [M-1:0]    max;
        logic [M-1:0]    step;
        logic [DIVW-1:0] div;
        logic            loop;
    } sweep_cfg_t;

    // Power-up sweep: full range, unit step, one step per wrap, triangle.
    localparam sweep_cfg_t CFG_DEFAULT = '{
        min:  '0,
        max:  '1,
        step: M'(1),
        div:  '0,
        loop: 1'b1
    };

    // A config with an empty range or a zero step cannot sweep; it parks at min.
    function automatic logic is_degenerate(input sweep_cfg_t c);
        return (c.min >= c.max) || (c.step == '0);
    endfunction

    state_t          state;
    state_t          state_nxt;
    sweep_cfg_t      active;
    sweep_cfg_t      shadow;
    logic            pending;
    logic            prev_msb;
    logic [DIVW-1:0] div_cnt;
    logic [DIVW-1:0] div_nxt;
    logic [M-1:0]    mod_nxt;

    logic            wrap;
    logic            accept;
    logic            apply;
    logic [M:0]      up_sum;
    logic [M:0]      down_gap;

    // Only the accumulator MSB matters here; the low bits feed the PWM comparator.
    logic            phase_unused;
    assign phase_unused = ^phase[N-2:0];

    // Falling MSB of the accumulator marks the start of a new PWM period.
    assign wrap = prev_msb & ~phase[N-1];

    // cfg_ready is the inverse of the pending flop, so it is glitch-free and
    // drops the cycle after an accept.
    assign cfg.cfg_ready = ~pending;
    assign accept        = cfg.cfg_valid & ~pending;

    // Shadow is applied at the next wrap while sweeping, immediately while idle.
    // An accept can never coincide with an apply (pending gates both), so an
    // offer taken on a wrap edge waits for the following wrap.
    assign apply = pending & ((state == IDLE) | wrap);

    // One extra bit keeps the step arithmetic from wrapping around.
    assign up_sum   = {1'b0, modulation} + {1'b0, active.step};
    assign down_gap = {1'b0, modulation} - {1'b0, active.min};

    // Next-state, next-duty and divider logic for the sweep FSM.
    // NOTE: every output gets a default at the top so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        mod_nxt   = modulation;
        div_nxt   = div_cnt;

        if (apply) begin
            mod_nxt = shadow.min;
            div_nxt = '0;
            if (!run)
                state_nxt = IDLE;
            else if (is_degenerate(shadow))
                state_nxt = HOLD;
            else
                state_nxt = UP;
        end else if (state == IDLE) begin
            if (run) begin
                mod_nxt   = active.min;
                div_nxt   = '0;
                state_nxt = is_degenerate(active) ? HOLD : UP;
            end
        end else if (!run) begin
            // Abort without waiting for a wrap; the duty value freezes.
            state_nxt = IDLE;
        end else if (wrap && (state == UP || state == DOWN)) begin
            if (div_cnt != active.div) begin
                div_nxt = div_cnt + 1'b1;
            end else begin
                div_nxt = '0;
                if (state == UP) begin
                    if (up_sum >= {1'b0, active.max}) begin
                        mod_nxt   = active.max;
                        state_nxt = active.loop ? DOWN : HOLD;
                    end else begin
                        mod_nxt = up_sum[M-1:0];
                    end
                end else begin
                    if ({1'b0, active.step} >= down_gap) begin
                        mod_nxt   = active.min;
                        state_nxt = UP;
                    end else begin
                        mod_nxt = modulation - active.step;
                    end
                end
            end
        end
    end

    // State, duty and status registers; outputs are registered from the next state.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    // NOTE: the config copies are a handful of flops, not a memory, so they are
    // reset to a known sweep like everything else.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            modulation <= '0;
            dir_down   <= 1'b0;
            busy       <= 1'b0;
            div_cnt    <= '0;
            prev_msb   <= 1'b0;
            pending    <= 1'b0;
            active     <= CFG_DEFAULT;
            shadow     <= CFG_DEFAULT;
        end else begin
            state      <= state_nxt;
            modulation <= mod_nxt;
            div_cnt    <= div_nxt;
            dir_down   <= (state_nxt == DOWN);
            busy       <= (state_nxt == UP) || (state_nxt == DOWN);
            prev_msb   <= phase[N-1];

            if (accept) begin
                pending     <= 1'b1;
                shadow.min  <= cfg.cfg_min;
                shadow.max  <= cfg.cfg_max;
                shadow.step <= cfg.cfg_step;
                shadow.div  <= cfg.cfg_div;
                shadow.loop <= cfg.cfg_loop;
            end else if (apply) begin
                pending <= 1'b0;
            end

            if (apply)
                active <= shadow;
        end
    end

endmodule

// File: tb/tb_pwm_mod_sweeper.sv
// Directed testbench for pwm_mod_sweeper.
// Phase is driven in jumps (…, 16383, 0, …) so every PWM period costs only a
// few clocks; the wrap edge is the one where phase goes from 16383 to 0.
module tb_pwm_mod_sweeper;

    localparam int N    = 14;
    localparam int M    = 12;
    localparam int DIVW = 8;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] phase;
    logic         run;
    logic [M-1:0] modulation;
    logic         dir_down;
    logic         busy;

    int checks = 0;
    int errors = 0;

    int tri_mod [9] = '{108, 116, 124, 130, 122, 114, 106, 100, 108};
    int tri_dir [9] = '{0,   0,   0,   1,   1,   1,   1,   0,   0};
    int rate_mod[6] = '{0, 0, 10, 10, 10, 20};
    int rate_bsy[6] = '{1, 1, 1,  1,  1,  0};

    pwm_mod_sweeper_if #(.M(M), .DIVW(DIVW)) cfg_if ();

    pwm_mod_sweeper #(.N(N), .M(M), .DIVW(DIVW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .phase      (phase),
        .run        (run),
        .cfg        (cfg_if),
        .modulation (modulation),
        .dir_down   (dir_down),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One period boundary: MSB high for an edge, then the wrap edge.
    // Returns on the falling edge just after the wrap edge.
    task automatic wrap_evt();
        phase = 14'h3FFF;
        @(negedge clk);
        phase = '0;
        @(negedge clk);
        phase = 14'd1;
    endtask

    task automatic set_cfg(input int mn, input int mx, input int st, input int dv, input logic lp);
        cfg_if.cfg_min  = M'(mn);
        cfg_if.cfg_max  = M'(mx);
        cfg_if.cfg_step = M'(st);
        cfg_if.cfg_div  = DIVW'(dv);
        cfg_if.cfg_loop = lp;
    endtask

    // Offer a config for one edge while cfg_ready is high.
    task automatic send_cfg(input int mn, input int mx, input int st, input int dv, input logic lp);
        set_cfg(mn, mx, st, dv, lp);
        cfg_if.cfg_valid = 1'b1;
        @(negedge clk);
        cfg_if.cfg_valid = 1'b0;
    endtask

    initial begin
        rst_n            = 1'b0;
        run              = 1'b0;
        phase            = '0;
        cfg_if.cfg_valid = 1'b0;
        set_cfg(0, 0, 0, 0, 1'b0);
        cyc(2);

        // Reset state
        check("rst_mod",   modulation,       0);
        check("rst_dir",   dir_down,         0);
        check("rst_busy",  busy,             0);
        check("rst_ready", cfg_if.cfg_ready, 1);
        rst_n = 1'b1;
        cyc(1);

        // Reset then run with the default config: +1 per wrap from 0
        run = 1'b1;
        cyc(1);
        check("run_start_mod",  modulation, 0);
        check("run_start_busy", busy,       1);
        check("run_start_dir",  dir_down,   0);
        for (int i = 0; i < 6; i++) begin
            phase = phase + 1'b1;
            @(negedge clk);
        end
        check("no_wrap_hold", modulation, 0);
        for (int i = 1; i <= 3; i++) begin
            wrap_evt();
            check($sformatf("default_up_%0d", i), modulation, i);
        end

        // Double buffering: offer 5 cycles after a wrap, applies at next wrap
        cyc(5);
        send_cfg(100, 130, 8, 0, 1'b1);
        check("db_ready_low", cfg_if.cfg_ready, 0);
        cyc(3);
        check("db_ready_still_low", cfg_if.cfg_ready, 0);
        check("db_no_early_apply",  modulation,       3);
        phase = 14'h3FFF;
        @(negedge clk);
        check("db_msb_high_no_apply", modulation, 3);
        phase = '0;
        @(negedge clk);
        phase = 14'd1;
        check("db_apply_min",   modulation,       100);
        check("db_ready_back",  cfg_if.cfg_ready, 1);
        check("db_busy",        busy,             1);

        // Triangle sweep 100..130 step 8
        for (int i = 0; i < 9; i++) begin
            wrap_evt();
            check($sformatf("tri_mod_%0d", i), modulation, tri_mod[i]);
            check($sformatf("tri_dir_%0d", i), dir_down,   tri_dir[i]);
        end

        // Accept on the same edge as a wrap: sweep steps, config waits
        phase = 14'h3FFF;
        @(negedge clk);
        phase = '0;
        set_cfg(0, 20, 10, 2, 1'b0);
        cfg_if.cfg_valid = 1'b1;
        @(negedge clk);
        cfg_if.cfg_valid = 1'b0;
        phase = 14'd1;
        check("same_edge_step",  modulation,       116);
        check("same_edge_ready", cfg_if.cfg_ready, 0);
        wrap_evt();
        check("same_edge_apply", modulation,       0);
        check("same_edge_rdy1",  cfg_if.cfg_ready, 1);

        // Rate divider (div=2) and one-shot 0..20 step 10
        for (int i = 0; i < 6; i++) begin
            wrap_evt();
            check($sformatf("rate_mod_%0d", i),  modulation, rate_mod[i]);
            check($sformatf("rate_busy_%0d", i), busy,       rate_bsy[i]);
        end
        for (int i = 0; i < 10; i++) begin
            wrap_evt();
            check($sformatf("hold_mod_%0d", i),  modulation, 20);
            check($sformatf("hold_busy_%0d", i), busy,       0);
        end

        // Degenerate: min > max parks at min
        send_cfg(200, 150, 5, 0, 1'b1);
        wrap_evt();
        check("degen_mod",   modulation,       200);
        check("degen_busy",  busy,             0);
        check("degen_dir",   dir_down,         0);
        check("degen_ready", cfg_if.cfg_ready, 1);
        for (int i = 0; i < 3; i++) begin
            wrap_evt();
            check($sformatf("degen_hold_%0d", i), modulation, 200);
        end
        // Degenerate: step = 0
        send_cfg(50, 100, 0, 0, 1'b1);
        wrap_evt();
        check("step0_mod",  modulation, 50);
        check("step0_busy", busy,       0);
        wrap_evt();
        check("step0_hold", modulation, 50);

        // Abort: run=0 mid-UP freezes the value without waiting for a wrap
        send_cfg(10, 1000, 3, 0, 1'b1);
        wrap_evt();
        check("abort_start", modulation, 10);
        check("abort_busy1", busy,       1);
        wrap_evt();
        wrap_evt();
        check("abort_pre", modulation, 16);
        run = 1'b0;
        @(negedge clk);
        check("abort_busy0", busy,       0);
        check("abort_mod",   modulation, 16);
        check("abort_dir",   dir_down,   0);
        wrap_evt();
        check("idle_frozen", modulation, 16);
        check("idle_busy",   busy,       0);

        // In IDLE the config applies on the very next edge
        send_cfg(7, 9, 1, 0, 1'b1);
        check("idle_ready_low", cfg_if.cfg_ready, 0);
        @(negedge clk);
        check("idle_apply_rdy", cfg_if.cfg_ready, 1);
        check("idle_apply_mod", modulation,       7);
        check("idle_apply_bsy", busy,             0);
        run = 1'b1;
        @(negedge clk);
        check("small_start_busy", busy,       1);
        check("small_start_mod",  modulation, 7);
        wrap_evt();
        check("small_8",   modulation, 8);
        wrap_evt();
        check("small_max", modulation, 9);
        check("small_dn",  dir_down,   1);
        wrap_evt();
        check("small_8b",  modulation, 8);
        check("small_dn2", dir_down,   1);
        wrap_evt();
        check("small_min", modulation, 7);
        check("small_up",  dir_down,   0);

        // Asynchronous reset between clock edges, with a config pending
        send_cfg(300, 400, 1, 0, 1'b1);
        check("pre_rst_ready", cfg_if.cfg_ready, 0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_mod",   modulation,       0);
        check("arst_dir",   dir_down,         0);
        check("arst_busy",  busy,             0);
        check("arst_ready", cfg_if.cfg_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_busy", busy,       1);
        check("post_rst_mod",  modulation, 0);
        wrap_evt();
        check("post_rst_step", modulation, 1);
        check("post_rst_rdy",  cfg_if.cfg_ready, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pwm_mod_sweeper.md
Name: pwm_mod_sweeper

Overview:
- Sequencer that drives the 12-bit `modulation` (duty) input of the PWM stage.
- Sweeps the duty value between a configured min and max, in a configured step, at a configured rate.
- Duty changes only at phase-accumulator wrap, so no PWM period ever sees a mid-period duty change.
- Configuration arrives over a valid/ready port and is double-buffered: shadow registers are applied at the next wrap.

Parameters:
- N, 14, phase accumulator width (matches PWM stage).
- M, 12, modulation/duty width.
- DIVW, 8, rate divider width (wraps per step, minus 1).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- phase  input  N  phase accumulator value, same signal the PWM stage sees.
- run  input  1  level; 1 = sweep enabled.
- cfg_valid  input  1  config offer.
- cfg_ready  output  1  config accept; equals not(pending).
- cfg_min  input  M  sweep lower bound.
- cfg_max  input  M  sweep upper bound.
- cfg_step  input  M  increment per step.
- cfg_div  input  DIVW  step every cfg_div+1 wraps.
- cfg_loop  input  1  1 = triangle loop; 0 = one-shot up, then hold.
- modulation  output  M  duty value to the PWM stage (registered).
- dir_down  output  1  1 while in DOWN state.
- busy  output  1  1 in UP or DOWN.

Behaviour:
- **Reset (async, rst_n=0):**
  - modulation=0, dir_down=0, busy=0, cfg_ready=1, pending=0, state=IDLE, prev_msb=0, div_cnt=0.
  - Active config: min=0, max=2^M-1, step=1, div=0, loop=1.
  - Shadow registers take the same values.
  - Reset mid-sweep aborts immediately; no completion.
- **Wrap detect:**
  - prev_msb <= phase[N-1] every cycle.
  - wrap = prev_msb & ~phase[N-1], i.e. the edge where phase is first seen with MSB falling.
- **Config handshake:**
  - Accept on cfg_valid & cfg_ready. Capture all cfg_* into shadow and set pending=1.
  - cfg_ready is the registered ~pending, so it deasserts the cycle after accept.
  - Apply (pending cleared, cfg_ready returns 1 the next cycle) happens:
    - at the next wrap edge, if state≠IDLE;
    - at the next edge, if state=IDLE.
  - Accept and wrap on the same edge: the new config waits for the following wrap.
  - On apply: active <= shadow; modulation <= min; div_cnt <= 0; state <= UP if run, else IDLE.
  - Degenerate config (min>=max or step=0): state <= HOLD if run, modulation=min.
- **States:** IDLE, UP, DOWN, HOLD. busy=1 in UP or DOWN only.
- **IDLE:**
  - modulation holds its last value.
  - run=1 → UP with modulation <= min, div_cnt <= 0. Degenerate config → HOLD instead.
- **run=0 in UP, DOWN or HOLD:** → IDLE on the next edge (no wait for wrap); modulation holds its value.
- **Rate divider:** evaluated only on wrap edges in UP or DOWN.
  - div_cnt==div: step and set div_cnt <= 0.
  - Otherwise: div_cnt+1.
- **Step arithmetic:** M+1-bit unsigned, no wrap-around.
  - **UP:** s = modulation+step.
    - s>=max: modulation <= max, then DOWN (loop=1) or HOLD (loop=0).
    - Otherwise: modulation <= s.
  - **DOWN:** if step>=modulation-min, modulation <= min and go to UP. Otherwise modulation <= modulation-step.
  - Bounds are always hit exactly; they are never overshot.
- **HOLD:** modulation constant. Leaves only via apply or run=0.
- **Latency:** the modulation update is visible in the cycle after the wrap edge. The PWM stage samples it on its next comparison; first use is in the new period.
- **dir_down** = (state==DOWN), registered with the state.

Test Plan:
- **Reset then run.** Reset, drive phase +1/cycle, run=1, no config. → modulation 0,1,2… incrementing by 1 one cycle after each wrap (every 16384 cycles). dir_down=0, busy=1.
- **Triangle sweep.** min=100, max=130, step=8, div=0, loop=1. → values 100,108,116,124,130,122,114,106,100,108… dir_down=1 exactly during the descending values.
- **Rate divider and one-shot.** div=2, loop=0, min=0, max=20, step=10. → changes every 3rd wrap: 0,10,20. Then HOLD at 20 with busy=0 over 10 more wraps.
- **Double buffering.** Mid-sweep, offer a config 5 cycles after a wrap. → cfg_ready low until the next wrap. modulation jumps to the new min exactly one cycle after that wrap, not before. Same-edge accept+wrap → applies one wrap later.
- **Degenerate config.** min=200, max=150, run=1. → HOLD, modulation=200 constant. step=0 behaves the same.
- **Abort.** run=0 mid-UP → IDLE next cycle, value frozen. rst_n pulse asserted between clock edges → all outputs at reset values without waiting for a clock edge.
